// File: rtl/osc_adc_clkgen.sv
// Programmable ADC sample-clock generator: divides clk by any N >= 2 in
// continuous or fixed-length burst mode, switching ratios only at period ends.
module osc_adc_clkgen #(
  parameter int DIV_W = 17,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             cfg_load,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             burst_start,
  output logic             clk_adc,
  output logic             sample_stb,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  logic [1:0]       state, state_next;
  logic [DIV_W-1:0] div_act, div_act_next;
  logic [DIV_W-1:0] pend_val, pend_val_next;
  logic             pend, pend_next;
  logic [DIV_W-1:0] cnt, cnt_next;
  logic [LEN_W-1:0] bcnt, bcnt_next;
  logic [DIV_W-1:0] nv;
  logic             boundary;
  logic             busy_next;
  logic             done_next;

  // Ratios below 2 cannot form a clock with both a high and a low phase.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  // High phase is ceil(N/2); widened so N = 2^DIV_W-1 does not overflow.
  function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] d);
    logic [DIV_W:0] sum;
    sum = {1'b0, d} + (DIV_W+1)'(1);
    return sum[DIV_W:1];
  endfunction

  always_comb begin
    nv            = clamp_div(div_val);
    boundary      = (state != IDLE) && (cnt == div_act - DIV_W'(1));
    state_next    = state;
    div_act_next  = div_act;
    pend_next     = pend;
    pend_val_next = pend_val;
    bcnt_next     = bcnt;
    done_next     = 1'b0;

    if (state == IDLE) begin
      if (cfg_load) div_act_next = nv;
    end else begin
      if (cfg_load) begin
        pend_next     = 1'b1;
        pend_val_next = nv;
      end
      // A load coinciding with the boundary is folded in through pend_next.
      if (boundary && pend_next) begin
        div_act_next = pend_val_next;
        pend_next    = 1'b0;
      end
    end

    case (state)
      IDLE: begin
        if (burst_start) begin
          if (burst_len != '0) begin
            state_next = BURST;
            bcnt_next  = burst_len;
          end else begin
            done_next = 1'b1;
          end
        end else if (en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (boundary && !en) state_next = IDLE;
      end
      BURST: begin
        if (boundary) begin
          bcnt_next = bcnt - LEN_W'(1);
          if (bcnt == LEN_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
    if (!busy_next || (state == IDLE) || boundary) cnt_next = '0;
    else                                           cnt_next = cnt + DIV_W'(1);
  end

  // Outputs are registered from next-state values so clk_adc and sample_stb
  // rise together on the first cycle of every period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_act    <= DIV_W'(2);
      pend_val   <= '0;
      pend       <= 1'b0;
      cnt        <= '0;
      bcnt       <= '0;
      clk_adc    <= 1'b0;
      sample_stb <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_next;
      div_act    <= div_act_next;
      pend_val   <= pend_val_next;
      pend       <= pend_next;
      cnt        <= cnt_next;
      bcnt       <= bcnt_next;
      clk_adc    <= busy_next && (cnt_next < high_len(div_act_next));
      sample_stb <= busy_next && (cnt_next == '0);
      done       <= done_next;
      cfg_err    <= cfg_load && (div_val < DIV_W'(2));
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_osc_adc_clkgen.sv
// Bench for osc_adc_clkgen: directed scenarios then random traffic, checked
// cycle by cycle against a period-level waveform model.
module tb_osc_adc_clkgen;
  localparam int DIV_W = 17;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             cfg_load = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             burst_start = 1'b0;
  logic             clk_adc, sample_stb, busy, done, cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  osc_adc_clkgen #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .cfg_load(cfg_load),
    .burst_len(burst_len), .burst_start(burst_start), .clk_adc(clk_adc),
    .sample_stb(sample_stb), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // Model: mode 0 idle, 1 continuous, 2 burst. Each started period pushes its
  // whole expected {clk_adc, sample_stb} waveform; an empty queue while active
  // means the cycle just shown was the last of its period.
  int         m_mode, m_div, m_pend, m_left;
  bit         m_pv;
  logic [1:0] wave[$];
  logic       e_clk, e_stb, e_busy, e_done, e_err;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_div = 2; m_pend = 0; m_left = 0; m_pv = 0;
    wave.delete();
    e_clk = 0; e_stb = 0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  task automatic start_period();
    for (int p = 0; p < m_div; p++)
      wave.push_back({logic'(p < (m_div + 1) / 2), logic'(p == 0)});
  endtask

  task automatic model_step();
    int nv;
    bit bnd;
    e_done = 0;
    e_err  = cfg_load && (div_val < 2);
    nv     = (div_val < 2) ? 2 : int'(div_val);
    if (m_mode == 0) begin
      if (cfg_load) m_div = nv;
      if (burst_start) begin
        if (burst_len != 0) begin
          m_mode = 2; m_left = int'(burst_len); start_period();
        end else e_done = 1;
      end else if (en) begin
        m_mode = 1; start_period();
      end
    end else begin
      bnd = (wave.size() == 0);
      if (cfg_load) begin m_pend = nv; m_pv = 1; end
      if (bnd) begin
        if (m_pv) begin m_div = m_pend; m_pv = 0; end
        if (m_mode == 1) begin
          if (!en) m_mode = 0;
          else start_period();
        end else begin
          m_left--;
          if (m_left == 0) begin m_mode = 0; e_done = 1; end
          else start_period();
        end
      end
    end
    if (wave.size() > 0) {e_clk, e_stb} = wave.pop_front();
    else {e_clk, e_stb} = 2'b00;
    e_busy = (m_mode != 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("clk_adc", int'(clk_adc), int'(e_clk));
    chk("sample_stb", int'(sample_stb), int'(e_stb));
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    chk("cfg_err", int'(cfg_err), int'(e_err));
    cfg_load = 1'b0;
    burst_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clk_adc"}, int'(clk_adc), 0);
    chk({tag, "_stb"}, int'(sample_stb), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  task automatic load(input int n);
    div_val = DIV_W'(n);
    cfg_load = 1'b1;
    tick();
  endtask

  initial begin
    int sb, bb, dd;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // N=4 continuous
    load(4);
    en = 1'b1;
    repeat (16) tick();
    en = 1'b0;
    repeat (8) tick();

    // N=5, then N=2 loaded while running
    load(5);
    en = 1'b1;
    repeat (15) tick();
    load(2);
    repeat (10) tick();
    en = 1'b0;
    repeat (6) tick();

    // retarget 4 -> 6 in the middle of a period
    load(4);
    en = 1'b1;
    tick();
    tick();
    load(6);
    repeat (20) tick();
    en = 1'b0;
    repeat (10) tick();

    // burst of 3 periods at N=4
    load(4);
    burst_len = LEN_W'(3);
    burst_start = 1'b1;
    sb = 0; bb = 0; dd = 0;
    repeat (16) begin
      tick();
      sb += int'(sample_stb); bb += int'(busy); dd += int'(done);
    end
    chk("burst_stb_count", sb, 3);
    chk("burst_busy_count", bb, 12);
    chk("burst_done_count", dd, 1);
    chk("burst_clk_after", int'(clk_adc), 0);

    // illegal ratios clamp to 2; zero-length burst
    load(0);
    load(1);
    en = 1'b1;
    repeat (6) tick();
    en = 1'b0;
    repeat (4) tick();
    burst_len = '0;
    burst_start = 1'b1;
    tick();
    chk("zero_burst_done", int'(done), 1);
    tick();

    // en dropped on cnt=0 at N=8
    load(8);
    en = 1'b1;
    tick();
    en = 1'b0;
    bb = 0;
    repeat (10) begin tick(); bb += int'(busy); end
    chk("en_drop_busy_count", bb, 7);

    // asynchronous reset in the middle of a burst
    load(4);
    burst_len = LEN_W'(5);
    burst_start = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    #2;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    // random traffic
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 14) == 0) begin
        div_val = DIV_W'($urandom_range(0, 9));
        cfg_load = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) begin
        burst_len = LEN_W'($urandom_range(0, 4));
        burst_start = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
